// File: rtl/uart_img_loader_if.sv
// Byte-in / pixel-out bundle of the UART image loader.
// master = byte source plus frame-buffer/status observer, slave = the loader itself.
interface uart_img_loader_if #(
  parameter int ADDR_W = 14
);
  logic              ld_en;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic              busy;
  logic              frame_done;
  logic              frame_err;

  modport master (
    output ld_en, rx_data, rx_ready,
    input  wr_en, wr_addr, wr_data, busy, frame_done, frame_err
  );

  modport slave (
    input  ld_en, rx_data, rx_ready,
    output wr_en, wr_addr, wr_data, busy, frame_done, frame_err
  );
endinterface

// File: rtl/uart_img_loader.sv
// UART image loader: hunts a 2-byte sync header, then packs byte pairs
// (high byte first) into RGB565 pixels written sequentially to the frame buffer.
module uart_img_loader #(
  parameter int         IMG_W       = 128,
  parameter int         IMG_H       = 128,
  parameter int         ADDR_W      = 14,
  parameter logic [7:0] SYNC_B0     = 8'hA5,
  parameter logic [7:0] SYNC_B1     = 8'h5A,
  parameter int         TIMEOUT_CYC = 100000
) (
  input logic             clk,
  input logic             clr,
  uart_img_loader_if.slave bus
);
  localparam int                NPIX     = IMG_W * IMG_H;
  localparam int                TW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(NPIX - 1);
  localparam logic [TW-1:0]     TMO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {HUNT0, HUNT1, PIX_HI, PIX_LO} state_t;

  state_t            state, state_n;
  logic              rx_ready_d, armed, byte_stb, tmo_hit;
  logic [7:0]        hi_q;
  logic [TW-1:0]     tmo_cnt;
  logic [ADDR_W-1:0] idx;
  logic              do_wr, do_err, do_done, ld_hi, idx_clr;

  // A rising edge only counts once rx_ready has been seen low after reset,
  // so a level already high when reset releases is not taken as a byte.
  assign byte_stb = bus.rx_ready & ~rx_ready_d & armed;
  assign tmo_hit  = (tmo_cnt == TMO_LAST);
  assign bus.busy = (state == PIX_HI) || (state == PIX_LO);

  // rx_ready edge detector and post-reset arming
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      rx_ready_d <= 1'b0;
      armed      <= 1'b0;
    end else begin
      rx_ready_d <= bus.rx_ready;
      if (!bus.rx_ready) armed <= 1'b1;
    end
  end

  // state register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= HUNT0;
    else      state <= state_n;
  end

  // next state and datapath controls; abort beats a byte, a byte beats timeout
  always_comb begin
    state_n = state;
    do_wr   = 1'b0;
    do_err  = 1'b0;
    do_done = 1'b0;
    ld_hi   = 1'b0;
    idx_clr = 1'b0;
    if (state == HUNT0) begin
      if (byte_stb && bus.ld_en && bus.rx_data == SYNC_B0) state_n = HUNT1;
    end else if (!bus.ld_en) begin
      state_n = HUNT0;
      do_err  = 1'b1;
      idx_clr = 1'b1;
    end else if (byte_stb) begin
      unique case (state)
        HUNT1: begin
          if (bus.rx_data == SYNC_B1) begin
            state_n = PIX_HI;
            idx_clr = 1'b1;
          end else if (bus.rx_data != SYNC_B0) begin
            state_n = HUNT0;
          end
        end
        PIX_HI: begin
          ld_hi   = 1'b1;
          state_n = PIX_LO;
        end
        PIX_LO: begin
          do_wr = 1'b1;
          if (idx == LAST) begin
            do_done = 1'b1;
            state_n = HUNT0;
          end else begin
            state_n = PIX_HI;
          end
        end
        default: state_n = HUNT0;
      endcase
    end else if (tmo_hit) begin
      state_n = HUNT0;
      do_err  = 1'b1;
      idx_clr = 1'b1;
    end
  end

  // pixel assembly, write port, status pulses, index and timeout counter
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      bus.wr_en      <= 1'b0;
      bus.wr_addr    <= '0;
      bus.wr_data    <= '0;
      bus.frame_done <= 1'b0;
      bus.frame_err  <= 1'b0;
      hi_q           <= '0;
      idx            <= '0;
      tmo_cnt        <= '0;
    end else begin
      bus.wr_en      <= do_wr;
      bus.frame_done <= do_done;
      bus.frame_err  <= do_err;
      if (ld_hi) hi_q <= bus.rx_data;
      if (do_wr) begin
        bus.wr_addr <= idx;
        bus.wr_data <= {hi_q, bus.rx_data};
      end
      if (idx_clr || do_done) idx <= '0;
      else if (do_wr)         idx <= idx + 1'b1;
      if (byte_stb || state == HUNT0) tmo_cnt <= '0;
      else                            tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_img_loader.sv
// Directed + randomized bench for uart_img_loader on a 4x2 image with a
// 1000-cycle byte timeout. Expected writes come from a stream-level model.
module tb_uart_img_loader;
  localparam int W = 4, H = 2, AW = 14, TMO = 1000, NPIX = W * H;
  typedef logic [7:0] u8;

  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  uart_img_loader_if #(.ADDR_W(AW)) bus();
  uart_img_loader #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .TIMEOUT_CYC(TMO))
    dut (.clk(clk), .clr(clr), .bus(bus));

  int n_cmp = 0, n_bad = 0, n_done = 0, n_err = 0;
  logic [31:0] got[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // write/pulse logger
  always @(negedge clk) begin
    if (clr) begin
      if (bus.wr_en) got.push_back({16'(bus.wr_addr), bus.wr_data});
      if (bus.frame_done) begin
        n_done++;
        chk("done_on_last_wr", {15'd0, bus.wr_en, 16'(bus.wr_addr)}, {15'd0, 1'b1, 16'(NPIX - 1)});
      end
      if (bus.frame_err) begin
        n_err++;
        chk("err_excl_done", 32'(bus.frame_done), 32'd0);
      end
    end
  end

  // Stream model: a frame starts after the first adjacent A5,5A pair; the
  // following byte pairs become pixels 0..NPIX-1; hunting resumes afterwards.
  task automatic model(input u8 s[$], output logic [31:0] w[$], output int fr);
    int i, k, p;
    w = {};
    fr = 0;
    i = 1;
    while (i < s.size()) begin
      if (s[i-1] == 8'hA5 && s[i] == 8'h5A) begin
        p = 0;
        k = i + 1;
        while (p < NPIX && k + 1 < s.size()) begin
          w.push_back({16'(p), s[k], s[k+1]});
          p++;
          k += 2;
        end
        if (p == NPIX) fr++;
        i = k + 1;
      end else begin
        i++;
      end
    end
  endtask

  task automatic clr_log();
    got = {};
    n_done = 0;
    n_err = 0;
  endtask

  task automatic send_byte(input u8 b);
    bus.rx_ready = 1'b0;
    bus.rx_data  = 8'($urandom_range(0, 255));
    repeat ($urandom_range(1, 4)) @(negedge clk);
    bus.rx_data  = b;
    bus.rx_ready = 1'b1;
    repeat ($urandom_range(1, 3)) @(negedge clk);
  endtask

  task automatic send_seq(input u8 s[$]);
    foreach (s[i]) send_byte(s[i]);
    bus.rx_ready = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic abort_frame();
    bus.ld_en = 1'b0;
    repeat (4) @(negedge clk);
    bus.ld_en = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_step(input string tag, input u8 s[$], input int exp_err,
                          input int pause_at, input int pause_len);
    logic [31:0] w[$];
    int fr;
    clr_log();
    foreach (s[i]) begin
      send_byte(s[i]);
      if (i == pause_at) begin
        bus.rx_ready = 1'b0;
        repeat (pause_len) @(negedge clk);
      end
    end
    bus.rx_ready = 1'b0;
    repeat (4) @(negedge clk);
    model(s, w, fr);
    chk({tag, "_nwr"}, got.size(), w.size());
    for (int i = 0; i < w.size() && i < got.size(); i++) chk({tag, "_wr"}, got[i], w[i]);
    chk({tag, "_done"}, n_done, fr);
    chk({tag, "_err"}, n_err, exp_err);
  endtask

  initial begin
    u8 s[$];
    bus.ld_en = 1'b1;
    bus.rx_ready = 1'b0;
    bus.rx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_wr_en", 32'(bus.wr_en), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.frame_done), 0);
    chk("rst_err", 32'(bus.frame_err), 0);
    chk("rst_addr", 32'(bus.wr_addr), 0);
    chk("rst_data", 32'(bus.wr_data), 0);
    clr = 1'b1;
    repeat (3) @(negedge clk);

    // full counting frame; last byte driven by hand to check write latency
    clr_log();
    s = {8'hA5, 8'h5A};
    for (int i = 0; i < 15; i++) s.push_back(8'(i));
    foreach (s[i]) send_byte(s[i]);
    bus.rx_ready = 1'b0;
    repeat (2) @(negedge clk);
    bus.rx_data = 8'h0F;
    bus.rx_ready = 1'b1;
    @(negedge clk);
    chk("lat_wr_en", 32'(bus.wr_en), 1);
    chk("lat_done", 32'(bus.frame_done), 1);
    chk("lat_addr", 32'(bus.wr_addr), 7);
    chk("lat_data", 32'(bus.wr_data), 32'h0E0F);
    @(negedge clk);
    chk("done_one_cycle", 32'(bus.frame_done), 0);
    bus.rx_ready = 1'b0;
    repeat (4) @(negedge clk);
    chk("cnt_nwr", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++)
      chk("cnt_wr", got[i], {16'(i), 8'(2 * i), 8'(2 * i + 1)});
    chk("cnt_ndone", n_done, 1);
    chk("cnt_busy", 32'(bus.busy), 0);

    // junk and repeated A5 before the header
    run_step("junk_sync", '{8'h11, 8'hA5, 8'hA5, 8'h5A, 8'h12, 8'h34}, 0, -1, 0);
    chk("junk_busy", 32'(bus.busy), 1);
    abort_frame();
    chk("junk_abort_err", n_err, 1);
    chk("junk_abort_busy", 32'(bus.busy), 0);

    // broken header never starts a frame
    run_step("bad_sync", '{8'hA5, 8'h22, 8'h5A, 8'h12, 8'h34}, 0, -1, 0);
    chk("bad_busy", 32'(bus.busy), 0);

    // timeout with a dangling high byte, then a clean restart
    clr_log();
    send_seq('{8'hA5, 8'h5A, 8'h12});
    repeat (1100) @(negedge clk);
    chk("tmo_err", n_err, 1);
    chk("tmo_nwr", got.size(), 0);
    chk("tmo_busy", 32'(bus.busy), 0);
    run_step("post_tmo", '{8'hA5, 8'h5A, 8'hAB, 8'hCD}, 0, -1, 0);
    abort_frame();

    // long but legal gap inside a frame
    s = {8'hA5, 8'h5A};
    for (int i = 0; i < 2 * NPIX; i++) s.push_back(8'($urandom_range(0, 255)));
    run_step("near_tmo", s, 0, 5, 980);

    // ld_en abort after three pixels, then a full frame restarts at 0
    clr_log();
    s = {8'hA5, 8'h5A};
    for (int i = 0; i < 6; i++) s.push_back(8'($urandom_range(0, 255)));
    send_seq(s);
    bus.ld_en = 1'b0;
    @(negedge clk);
    chk("abort_err", 32'(bus.frame_err), 1);
    chk("abort_busy", 32'(bus.busy), 0);
    @(negedge clk);
    chk("abort_err_one", 32'(bus.frame_err), 0);
    chk("abort_nwr", got.size(), 3);
    for (int i = 0; i < 3 && i < got.size(); i++)
      chk("abort_wr", got[i], {16'(i), s[2 + 2 * i], s[3 + 2 * i]});
    bus.ld_en = 1'b1;
    s = {8'hA5, 8'h5A};
    for (int i = 0; i < 2 * NPIX; i++) s.push_back(8'($urandom_range(0, 255)));
    run_step("refill", s, 0, -1, 0);

    // ld_en low while hunting: everything ignored, no error
    bus.ld_en = 1'b0;
    clr_log();
    send_seq('{8'hA5, 8'h5A, 8'h12, 8'h34});
    chk("dis_nwr", got.size(), 0);
    chk("dis_err", n_err, 0);
    chk("dis_busy", 32'(bus.busy), 0);
    bus.ld_en = 1'b1;

    // random streams: junk prefix, one or two full frames
    for (int r = 0; r < 6; r++) begin
      s = {};
      repeat ($urandom_range(0, 4)) s.push_back(($urandom_range(0, 3) == 0) ? 8'hA5 : 8'($urandom_range(0, 255)));
      for (int f = 0; f < 1 + (r % 2); f++) begin
        s.push_back(8'hA5);
        s.push_back(8'h5A);
        for (int i = 0; i < 2 * NPIX; i++) s.push_back(8'($urandom_range(0, 255)));
      end
      run_step("rand", s, 0, -1, 0);
      abort_frame();
    end

    // async reset mid-frame, rx_ready held high across reset release
    clr_log();
    send_seq('{8'hA5, 8'h5A, 8'h12, 8'h34, 8'h56});
    #3 clr = 1'b0;
    #1;
    chk("arst_addr_data", {16'(bus.wr_addr), bus.wr_data}, 0);
    chk("arst_busy", 32'(bus.busy), 0);
    bus.rx_data = 8'hA5;
    bus.rx_ready = 1'b1;
    @(negedge clk);
    #2 clr = 1'b1;
    repeat (3) @(negedge clk);
    clr_log();
    send_seq('{8'h5A, 8'h12, 8'h34});
    chk("arst_nwr", got.size(), 0);
    chk("arst_busy_after", 32'(bus.busy), 0);
    run_step("after_rst", '{8'hA5, 8'h5A, 8'h77, 8'h88}, 0, -1, 0);
    abort_frame();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_img_loader.md
Name: uart_img_loader

Overview:
Receive-side sequencer for the UART image path. Consumes bytes from the UART byte receiver (rx_data/rx_ready), hunts a 2-byte sync header, then assembles RGB565 pixels (high byte first) and writes them sequentially into the frame-buffer write port. Covers frame completion, inter-byte timeout and abort, and reports status to the display top level.

Parameters:
IMG_W, 128, image width in pixels
IMG_H, 128, image height in pixels
ADDR_W, 14, frame-buffer address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
SYNC_B0, 8'hA5, first header byte
SYNC_B1, 8'h5A, second header byte
TIMEOUT_CYC, 100000, max clk cycles allowed between bytes inside a frame

Ports:
clk  input  1  system clock (50 MHz)
clr  input  1  asynchronous active-low reset
ld_en  input  1  loader enable; low = ignore bytes / abort frame
rx_data  input  8  received byte, valid when rx_ready rises
rx_ready  input  1  byte-ready level from UART receiver; rising edge = new byte
wr_en  output  1  frame-buffer write strobe, one cycle per pixel
wr_addr  output  ADDR_W  pixel address, 0 .. IMG_W*IMG_H-1
wr_data  output  16  pixel {hi_byte, lo_byte}
busy  output  1  high while in PIX_HI or PIX_LO
frame_done  output  1  one-cycle pulse on last pixel write
frame_err  output  1  one-cycle pulse on timeout or ld_en abort

Behaviour:
- Reset (clr low, async): state HUNT0; wr_en, busy, frame_done, frame_err = 0; wr_addr = 0; wr_data = 0; hi-byte latch, timeout counter, rx_ready delay reg = 0.
- byte_stb = rx_ready & ~rx_ready_d (rx_ready_d registered rx_ready). rx_data is sampled in the byte_stb cycle. Only byte_stb advances the FSM; a level held high counts once.
- States:
  - HUNT0: on byte_stb with rx_data==SYNC_B0 -> HUNT1; other bytes ignored.
  - HUNT1: byte_stb with SYNC_B1 -> PIX_HI, pixel index = 0; with SYNC_B0 -> stay HUNT1; other -> HUNT0.
  - PIX_HI: byte_stb latches hi byte -> PIX_LO.
  - PIX_LO: byte_stb -> next cycle wr_en=1, wr_data={hi,rx_data}, wr_addr=current index; index then increments. If index == IMG_W*IMG_H-1: frame_done=1 in the same cycle as that wr_en, state -> HUNT0, index -> 0; else -> PIX_HI.
- Write latency: wr_en asserts exactly 1 cycle after the low-byte byte_stb. wr_addr/wr_data hold their values until the next write (or abort/reset).
- Timeout: counter clears on every byte_stb and while in HUNT0; increments in HUNT1/PIX_HI/PIX_LO. Reaching TIMEOUT_CYC-1 without a byte -> frame_err pulse, state HUNT0, index 0. No write occurs for a dangling hi byte.
- ld_en low: in HUNT0, all bytes ignored (stay HUNT0). In any other state -> frame_err pulse next cycle, HUNT0, index 0. byte_stb coinciding with ld_en falling: abort wins, byte dropped.
- Timeout and byte_stb in same cycle: byte wins, counter clears.
- frame_err and frame_done never assert together; frame_done cycle always returns to HUNT0 even if ld_en drops that cycle.
- Partial frames are never rolled back; frame buffer keeps already-written pixels.
- Index arithmetic is ADDR_W wide; no wrap past IMG_W*IMG_H-1 is possible.

Test Plan:
- IMG_W=4, IMG_H=2; send A5 5A then 16 bytes 00 01 .. 0F -> 8 wr_en pulses, addr 0..7, data 0x0001,0x0203..0x0E0F; frame_done with addr 7; busy low after.
- Send 11 A5 A5 5A 12 34 -> first pixel wr_addr 0, wr_data 0x1234 (leading junk and repeated A5 tolerated).
- Send A5 22 5A 12 34 -> no wr_en; loader stays hunting.
- TIMEOUT_CYC=1000; A5 5A 12 then 1000 idle cycles -> frame_err one-cycle pulse, no write; following A5 5A AB CD -> write addr 0 data 0xABCD.
- Mid-frame after 3 pixels drop ld_en -> frame_err pulse, busy low; raise ld_en, send full frame -> addresses restart at 0, frame_done at addr 7.
- Assert clr low mid-frame (async, between clock edges) -> outputs 0 immediately; hold rx_ready high across reset release -> no spurious byte accepted.
